reset_signaling_tx: RTL and testbench

RESET_SIGNALING_TX -- requirements
Module: reset_signaling_tx

---
 rtl/reset_tx_pkg.sv | 16 +
 rtl/reset_signaling_tx_if.sv | 29 ++
 rtl/reset_tx_timer.sv | 19 +
 rtl/reset_signaling_tx.sv | 89 ++++++++
 tb/tb_reset_signaling_tx.sv | 167 ++++++++++++++++
 5 files changed

// File: rtl/reset_tx_pkg.sv
// reset_tx_pkg: shared state encodings, reset-type constants and type check for reset_signaling_tx
package reset_tx_pkg;
  typedef enum logic [5:0] {
    IDLE     = 6'b000001,
    REQUEST  = 6'b000010,
    WAIT_PHY = 6'b000100,
    SUCCESS  = 6'b001000,
    FAILURE  = 6'b010000,
    REPORT   = 6'b100000
  } state_e;
  localparam logic [2:0] TYPE_HARD_RESET  = 3'b101;
  localparam logic [2:0] TYPE_CABLE_RESET = 3'b110;
  function automatic logic is_reset_type(input logic [2:0] t);
    return t == TYPE_HARD_RESET || t == TYPE_CABLE_RESET;
  endfunction
endpackage

// File: rtl/reset_signaling_tx_if.sv
// reset_signaling_tx_if: request/PHY/alert signals of the reset signaling transmitter
// master drives transmit_valid, TRANSMIT, max_reset_timer, phy_response;
// slave (the transmitter) drives phy_request, phy_type, busy, alerts, retries_used.
interface reset_signaling_tx_if #(
  parameter int TIMER_W = 16,
  parameter int RETRY_W = 2
);
  logic               transmit_valid;
  logic [7:0]         TRANSMIT;
  logic [TIMER_W-1:0] max_reset_timer;
  logic               phy_response;
  logic               phy_request;
  logic [2:0]         phy_type;
  logic               busy;
  logic               ALERT_TransmitSuccessful;
  logic               ALERT_TransmitSOPMessageFailed;
  logic               ALERT_TransmitDiscarded;
  logic [RETRY_W-1:0] retries_used;
  modport master (
    output transmit_valid, TRANSMIT, max_reset_timer, phy_response,
    input  phy_request, phy_type, busy, ALERT_TransmitSuccessful,
           ALERT_TransmitSOPMessageFailed, ALERT_TransmitDiscarded, retries_used
  );
  modport slave (
    input  transmit_valid, TRANSMIT, max_reset_timer, phy_response,
    output phy_request, phy_type, busy, ALERT_TransmitSuccessful,
           ALERT_TransmitSOPMessageFailed, ALERT_TransmitDiscarded, retries_used
  );
endinterface

// File: rtl/reset_tx_timer.sv
// reset_tx_timer: loadable saturating down-counter with zero flag
// ports: clk, reset_L (async active-low), load/load_val, dec, zero.
module reset_tx_timer #(
  parameter int TIMER_W = 16
) (
  input  logic               clk,
  input  logic               reset_L,
  input  logic               load,
  input  logic               dec,
  input  logic [TIMER_W-1:0] load_val,
  output logic               zero
);
  logic [TIMER_W-1:0] count_q, count_d;
  always_comb count_d = load ? load_val : (dec && count_q != '0) ? count_q - TIMER_W'(1) : count_q;
  always_ff @(posedge clk or negedge reset_L)
    if (!reset_L) count_q <= '0;
    else count_q <= count_d;
  assign zero = count_q == '0;
endmodule

// File: rtl/reset_signaling_tx.sv
// reset_signaling_tx: hard/cable reset signaling transmitter with timeout, retries and alerts
// ports: clk, reset_L (async active-low), bus (reset_signaling_tx_if.slave).
// RESET_TX_RETRY_EN: when defined, the retry limit comes from TRANSMIT[RETRY_W+3:4]; otherwise it is 0.
module reset_signaling_tx
  import reset_tx_pkg::*;
#(
  parameter int TIMER_W = 16,
  parameter int RETRY_W = 2
) (
  input logic                clk,
  input logic                reset_L,
  reset_signaling_tx_if.slave bus
);
  state_e             state_q, state_d;
  logic [2:0]         type_q, type_d;
  logic [RETRY_W-1:0] limit_q, limit_d, retries_q, retries_d;
  logic               outcome_q, outcome_d, discard_q, discard_d;
  logic               load, dec, zero;
  logic               unused_transmit;
  assign unused_transmit = ^bus.TRANSMIT[7:3];
  reset_tx_timer #(.TIMER_W(TIMER_W)) u_timer (
    .clk(clk), .reset_L(reset_L), .load(load), .dec(dec),
    .load_val(bus.max_reset_timer), .zero(zero)
  );
  always_comb begin
    state_d   = state_q;
    type_d    = type_q;
    limit_d   = limit_q;
    retries_d = retries_q;
    outcome_d = outcome_q;
    load      = 1'b0;
    dec       = 1'b0;
    discard_d = bus.transmit_valid && state_q != IDLE;
    case (state_q)
      IDLE: if (bus.transmit_valid && is_reset_type(bus.TRANSMIT[2:0])) begin
        state_d   = REQUEST;
        type_d    = bus.TRANSMIT[2:0];
`ifdef RESET_TX_RETRY_EN
        limit_d   = bus.TRANSMIT[RETRY_W+3:4];
`else
        limit_d   = '0;
`endif
        retries_d = '0;
      end
      REQUEST: begin
        load    = 1'b1;
        state_d = WAIT_PHY;
      end
      WAIT_PHY:
        if (bus.phy_response) state_d = SUCCESS;
        else if (zero) begin
          state_d   = retries_q < limit_q ? REQUEST : FAILURE;
          retries_d = retries_q < limit_q ? retries_q + RETRY_W'(1) : retries_q;
        end else dec = 1'b1;
      SUCCESS: begin
        outcome_d = 1'b1;
        state_d   = REPORT;
      end
      FAILURE: begin
        outcome_d = 1'b0;
        state_d   = REPORT;
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge reset_L)
    if (!reset_L) begin
      state_q   <= IDLE;
      type_q    <= '0;
      limit_q   <= '0;
      retries_q <= '0;
      outcome_q <= 1'b0;
      discard_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      type_q    <= type_d;
      limit_q   <= limit_d;
      retries_q <= retries_d;
      outcome_q <= outcome_d;
      discard_q <= discard_d;
    end
  assign bus.phy_request                    = state_q == WAIT_PHY;
  assign bus.phy_type                       = type_q;
  assign bus.busy                           = state_q != IDLE;
  assign bus.ALERT_TransmitSuccessful       = state_q == REPORT && outcome_q;
  assign bus.ALERT_TransmitSOPMessageFailed = state_q == REPORT && !outcome_q;
  assign bus.ALERT_TransmitDiscarded        = discard_q;
  assign bus.retries_used                   = retries_q;
endmodule

// File: tb/tb_reset_signaling_tx.sv
// tb_reset_signaling_tx: table-driven scoreboard bench for reset_signaling_tx
module tb_reset_signaling_tx;
  localparam int TW = 16;
  localparam int RW = 2;
`ifdef RESET_TX_RETRY_EN
  localparam bit RETRY = 1'b1;
`else
  localparam bit RETRY = 1'b0;
`endif
  typedef struct {
    logic [7:0] tr;
    int         tmr;
    int         resp;
    int         disc;
    logic [7:0] disc_tr;
    bit         succ;
    int         ret;
    int         att;
    logic [2:0] typ;
  } vec_t;
  typedef struct {
    bit         succ;
    int         ret;
    logic [2:0] typ;
  } exp_t;
  logic clk = 1'b0;
  logic reset_L = 1'b0;
  int   pass = 0;
  int   total = 0;
  exp_t sb[$];
  vec_t vecs[8];
  always #5 clk = ~clk;
  reset_signaling_tx_if #(.TIMER_W(TW), .RETRY_W(RW)) bus ();
  reset_signaling_tx #(.TIMER_W(TW), .RETRY_W(RW)) dut (.clk(clk), .reset_L(reset_L), .bus(bus));
  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act == exp) pass++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask
  always @(negedge clk)
    if (reset_L && (bus.ALERT_TransmitSuccessful || bus.ALERT_TransmitSOPMessageFailed)) begin
      exp_t e;
      if (sb.size() == 0) check("sb_unexpected_alert", 1, 0);
      else begin
        e = sb.pop_front();
        check("sb_onehot", int'(bus.ALERT_TransmitSuccessful) + int'(bus.ALERT_TransmitSOPMessageFailed), 1);
        check("sb_outcome", int'(bus.ALERT_TransmitSuccessful), int'(e.succ));
        check("sb_retries", int'(bus.retries_used), e.ret);
        check("sb_type", int'(bus.phy_type), int'(e.typ));
      end
    end
  task automatic run_vec(input int idx, input vec_t v);
    int  wc = 0, att = 0, rc = -100, nsucc = 0, nfail = 0, ndisc = 0;
    bit  prev_req = 1'b0, done = 1'b0;
    @(negedge clk);
    bus.transmit_valid = 1'b1;
    bus.TRANSMIT = v.tr;
    bus.max_reset_timer = TW'(v.tmr);
    sb.push_back('{v.succ, v.ret, v.typ});
    for (int c = 1; c < 300 && !done; c++) begin
      @(negedge clk);
      bus.transmit_valid = 1'b0;
      bus.phy_response = 1'b0;
      if (c == 1) begin
        check($sformatf("v%0d_req_gap", idx), int'(bus.phy_request), 0);
        check($sformatf("v%0d_type", idx), int'(bus.phy_type), int'(v.typ));
      end
      if (c == 2) check($sformatf("v%0d_req_latency", idx), int'(bus.phy_request), 1);
      if (bus.ALERT_TransmitSuccessful) begin
        nsucc++;
        check($sformatf("v%0d_succ_latency", idx), c - rc, 2);
      end
      if (bus.ALERT_TransmitSOPMessageFailed) nfail++;
      if (bus.ALERT_TransmitDiscarded) ndisc++;
      if (!bus.busy) done = 1'b1;
      else begin
        if (bus.phy_request && !prev_req) att++;
        prev_req = bus.phy_request;
        if (bus.phy_request) begin
          if (wc == v.resp) begin
            bus.phy_response = 1'b1;
            rc = c;
          end
          if (wc == v.disc) begin
            bus.transmit_valid = 1'b1;
            bus.TRANSMIT = v.disc_tr;
          end
          wc++;
        end
      end
    end
    bus.transmit_valid = 1'b0;
    bus.phy_response = 1'b0;
    check($sformatf("v%0d_timeout", idx), int'(done), 1);
    check($sformatf("v%0d_succ_pulses", idx), nsucc, v.succ ? 1 : 0);
    check($sformatf("v%0d_fail_pulses", idx), nfail, v.succ ? 0 : 1);
    check($sformatf("v%0d_discards", idx), ndisc, v.disc >= 0 ? 1 : 0);
    check($sformatf("v%0d_attempts", idx), att, v.att);
    check($sformatf("v%0d_retries_used", idx), int'(bus.retries_used), v.ret);
    check($sformatf("v%0d_sb_drained", idx), sb.size(), 0);
  endtask
  initial begin
    int n;
    bus.transmit_valid = 1'b0;
    bus.TRANSMIT = '0;
    bus.max_reset_timer = '0;
    bus.phy_response = 1'b0;
    vecs[0] = '{8'h05, 10, 3, -1, 8'h00, 1'b1, 0, 1, 3'b101};
    vecs[1] = '{8'h26, 3, -1, -1, 8'h00, 1'b0, RETRY ? 2 : 0, RETRY ? 3 : 1, 3'b110};
    vecs[2] = '{8'h06, 0, 0, -1, 8'h00, 1'b1, 0, 1, 3'b110};
    vecs[3] = '{8'h25, 2, 2, -1, 8'h00, 1'b1, 0, 1, 3'b101};
    vecs[4] = '{8'h16, 1, 3, -1, 8'h00, RETRY, RETRY ? 1 : 0, RETRY ? 2 : 1, 3'b110};
    vecs[5] = '{8'h05, 0, -1, -1, 8'h00, 1'b0, 0, 1, 3'b101};
    vecs[6] = '{8'h05, 10, 5, 1, 8'h05, 1'b1, 0, 1, 3'b101};
    vecs[7] = '{8'h16, 3, -1, 0, 8'h35, 1'b0, RETRY ? 1 : 0, RETRY ? 2 : 1, 3'b110};
    @(negedge clk);
    check("rst_busy", int'(bus.busy), 0);
    check("rst_phy_request", int'(bus.phy_request), 0);
    check("rst_phy_type", int'(bus.phy_type), 0);
    check("rst_retries", int'(bus.retries_used), 0);
    check("rst_alerts", int'(bus.ALERT_TransmitSuccessful) + int'(bus.ALERT_TransmitSOPMessageFailed) + int'(bus.ALERT_TransmitDiscarded), 0);
    @(negedge clk);
    reset_L = 1'b1;
    for (int i = 0; i < 8; i++) run_vec(i, vecs[i]);
    @(negedge clk);
    bus.transmit_valid = 1'b1;
    bus.TRANSMIT = 8'h05;
    bus.max_reset_timer = TW'(10);
    @(negedge clk);
    bus.transmit_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check("mid_rst_in_wait", int'(bus.phy_request), 1);
    #1 reset_L = 1'b0;
    #1;
    check("mid_rst_phy_request", int'(bus.phy_request), 0);
    check("mid_rst_busy", int'(bus.busy), 0);
    check("mid_rst_phy_type", int'(bus.phy_type), 0);
    check("mid_rst_retries", int'(bus.retries_used), 0);
    check("mid_rst_alerts", int'(bus.ALERT_TransmitSuccessful) + int'(bus.ALERT_TransmitSOPMessageFailed) + int'(bus.ALERT_TransmitDiscarded), 0);
    @(negedge clk);
    @(negedge clk);
    reset_L = 1'b1;
    n = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      n += int'(bus.busy) + int'(bus.ALERT_TransmitSuccessful) + int'(bus.ALERT_TransmitSOPMessageFailed) + int'(bus.ALERT_TransmitDiscarded);
    end
    check("post_rst_quiet", n, 0);
    @(negedge clk);
    bus.transmit_valid = 1'b1;
    bus.TRANSMIT = 8'h03;
    bus.phy_response = 1'b1;
    @(negedge clk);
    bus.transmit_valid = 1'b0;
    n = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      n += int'(bus.busy) + int'(bus.phy_request) + int'(bus.ALERT_TransmitSuccessful) + int'(bus.ALERT_TransmitSOPMessageFailed) + int'(bus.ALERT_TransmitDiscarded);
    end
    bus.phy_response = 1'b0;
    check("bad_type_ignored", n, 0);
    check("final_sb_empty", sb.size(), 0);
    $display("%0d/%0d checks passed", pass, total);
    $finish;
  end
endmodule
